// File: rtl/cmp_arb_pkg.sv
// Shared types and funct3 encodings for the shared comparator arbiter.
package cmp_arb_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {IDLE, RSP_BR, RSP_SLT} state_t;
  typedef enum logic {REQ_BR, REQ_SLT} req_id_t;

  // funct3 values 010 and 011 are the only non-branch encodings.
  function automatic logic isBranchF3(input logic [2:0] f3);
    return f3[2] | ~f3[1];
  endfunction

endpackage

// File: rtl/cmp_core.sv
// Combinational 32-bit equality / less-than comparator, signed or unsigned.
module cmp_core #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            isUnsigned,
  output logic            eq,
  output logic            lt
);

  // A signed compare only differs from unsigned when the sign bits differ;
  // then the operand with the sign bit set is the smaller one.
  always_comb begin
    eq = (a == b);
    if (!isUnsigned && (a[XLEN-1] != b[XLEN-1])) begin
      lt = a[XLEN-1];
    end else begin
      lt = (a < b);
    end
  end

endmodule

// File: rtl/cmp_share_arbiter.sv
// Arbitrates one comparator between a branch-resolution requester and an
// SLT requester, returning registered results on per-requester channels.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; the producer holds valid and payload stable until that edge, and a
// response holds rsp_valid and its data stable until rsp_ready is seen.
module cmp_share_arbiter
  import cmp_arb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_br_valid,
  output logic            o_br_ready,
  input  logic [XLEN-1:0] i_br_rs1_data,
  input  logic [XLEN-1:0] i_br_rs2_data,
  input  logic [2:0]      i_br_funct3,
  output logic            o_br_rsp_valid,
  input  logic            i_br_rsp_ready,
  output logic            o_br_taken,
  output logic            o_br_illegal,
  input  logic            i_slt_valid,
  output logic            o_slt_ready,
  input  logic [XLEN-1:0] i_slt_a,
  input  logic [XLEN-1:0] i_slt_b,
  input  logic            i_slt_unsigned,
  output logic            o_slt_rsp_valid,
  input  logic            i_slt_rsp_ready,
  output logic [XLEN-1:0] o_slt_result,
  output state_t          o_dbg_state
);

  state_t          state;
  req_id_t         lastGrant;
  logic            grantBr;
  logic            grantSlt;
  logic            rspHs;
  logic            slotFree;
  logic            brAccept;
  logic            sltAccept;
  logic [XLEN-1:0] opA;
  logic [XLEN-1:0] opB;
  logic            opUnsigned;
  logic            cmpEq;
  logic            cmpLt;
  logic            takenNext;
  logic            illegalNext;

  assign o_dbg_state = state;

  // Grant: a lone requester wins; on a tie, round-robin or fixed branch priority.
  always_comb begin
    grantBr  = i_br_valid & (~i_slt_valid | (FIXED_PRIO != 0) | (lastGrant == REQ_SLT));
    grantSlt = i_slt_valid & ~grantBr;
  end

  // A new request may enter when nothing is outstanding or the outstanding
  // response is being consumed this cycle (back-to-back without a bubble).
  always_comb begin
    rspHs     = (o_br_rsp_valid & i_br_rsp_ready) | (o_slt_rsp_valid & i_slt_rsp_ready);
    slotFree  = (state == IDLE) | rspHs;
    o_br_ready  = grantBr & slotFree;
    o_slt_ready = grantSlt & slotFree;
    brAccept  = i_br_valid & o_br_ready;
    sltAccept = i_slt_valid & o_slt_ready;
  end

  // Steer the granted requester's operands into the single comparator.
  always_comb begin
    opA        = grantBr ? i_br_rs1_data  : i_slt_a;
    opB        = grantBr ? i_br_rs2_data  : i_slt_b;
    opUnsigned = grantBr ? i_br_funct3[1] : i_slt_unsigned;
  end

  cmp_core #(.XLEN(XLEN)) u_cmp_core (
    .a          (opA),
    .b          (opB),
    .isUnsigned (opUnsigned),
    .eq         (cmpEq),
    .lt         (cmpLt)
  );

  // Map funct3 onto the comparator outputs; non-branch encodings flag illegal.
  always_comb begin
    takenNext   = 1'b0;
    illegalNext = ~isBranchF3(i_br_funct3);
    case (i_br_funct3)
      F3_BEQ:           takenNext = cmpEq;
      F3_BNE:           takenNext = ~cmpEq;
      F3_BLT,  F3_BLTU: takenNext = cmpLt;
      F3_BGE,  F3_BGEU: takenNext = ~cmpLt;
      default:          takenNext = 1'b0;
    endcase
  end

  // FSM: capture results on accept, release the channel on response handshake.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= IDLE;
      lastGrant       <= REQ_SLT;
      o_br_rsp_valid  <= 1'b0;
      o_slt_rsp_valid <= 1'b0;
      o_br_taken      <= 1'b0;
      o_br_illegal    <= 1'b0;
      o_slt_result    <= '0;
    end else if (brAccept) begin
      state           <= RSP_BR;
      lastGrant       <= REQ_BR;
      o_br_rsp_valid  <= 1'b1;
      o_slt_rsp_valid <= 1'b0;
      o_br_taken      <= takenNext;
      o_br_illegal    <= illegalNext;
    end else if (sltAccept) begin
      state           <= RSP_SLT;
      lastGrant       <= REQ_SLT;
      o_br_rsp_valid  <= 1'b0;
      o_slt_rsp_valid <= 1'b1;
      o_slt_result    <= {{(XLEN-1){1'b0}}, cmpLt};
    end else if (rspHs) begin
      state           <= IDLE;
      o_br_rsp_valid  <= 1'b0;
      o_slt_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Bench for cmp_share_arbiter: directed corner cases plus random traffic,
// with an expected-response queue filled on accept and drained by a monitor.
module tb_cmp_share_arbiter;
  import cmp_arb_pkg::*;

  localparam int XLEN       = 32;
  localparam int FIXED_PRIO = 0;
  localparam int W          = 34;   // {channel, illegal, data[31:0]}

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            brValid = 1'b0;
  logic [XLEN-1:0] brRs1 = '0;
  logic [XLEN-1:0] brRs2 = '0;
  logic [2:0]      brF3 = '0;
  logic            brRspReady = 1'b1;
  logic            sltValid = 1'b0;
  logic [XLEN-1:0] sltA = '0;
  logic [XLEN-1:0] sltB = '0;
  logic            sltUns = 1'b0;
  logic            sltRspReady = 1'b1;

  logic            o_br_ready;
  logic            o_br_rsp_valid;
  logic            o_br_taken;
  logic            o_br_illegal;
  logic            o_slt_ready;
  logic            o_slt_rsp_valid;
  logic [XLEN-1:0] o_slt_result;
  state_t          dbgState;

  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  // stimulus control
  bit randMode = 1'b0;
  bit fillBoth = 1'b0;
  bit brAccNow, sltAccNow;
  int accCount, brAccCount;

  // monitor-side model state
  bit mLastBr = 1'b0;
  bit pendBr = 1'b0, pendSlt = 1'b0;
  bit brHeld = 1'b0, sltHeld = 1'b0;
  logic [1:0]      heldBr;
  logic [XLEN-1:0] heldRes;

  cmp_share_arbiter #(.XLEN(XLEN), .FIXED_PRIO(FIXED_PRIO)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_br_valid      (brValid),
    .o_br_ready      (o_br_ready),
    .i_br_rs1_data   (brRs1),
    .i_br_rs2_data   (brRs2),
    .i_br_funct3     (brF3),
    .o_br_rsp_valid  (o_br_rsp_valid),
    .i_br_rsp_ready  (brRspReady),
    .o_br_taken      (o_br_taken),
    .o_br_illegal    (o_br_illegal),
    .i_slt_valid     (sltValid),
    .o_slt_ready     (o_slt_ready),
    .i_slt_a         (sltA),
    .i_slt_b         (sltB),
    .i_slt_unsigned  (sltUns),
    .o_slt_rsp_valid (o_slt_rsp_valid),
    .i_slt_rsp_ready (sltRspReady),
    .o_slt_result    (o_slt_result),
    .o_dbg_state     (dbgState)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] br_model(input logic [XLEN-1:0] a, b, input logic [2:0] f3);
    logic taken;
    logic illegal;
    illegal = 1'b0;
    case (f3)
      3'b000:  taken = (a == b);
      3'b001:  taken = (a != b);
      3'b100:  taken = ($signed(a) <  $signed(b));
      3'b101:  taken = ($signed(a) >= $signed(b));
      3'b110:  taken = (a <  b);
      3'b111:  taken = (a >= b);
      default: begin taken = 1'b0; illegal = 1'b1; end
    endcase
    return {1'b0, illegal, 31'b0, taken};
  endfunction

  function automatic logic [W-1:0] slt_model(input logic [XLEN-1:0] a, b, input logic uns);
    logic lt;
    lt = uns ? (a < b) : ($signed(a) < $signed(b));
    return {1'b1, 1'b0, 31'b0, lt};
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops on every response handshake, pushes on every accept.
  task automatic monitor();
    logic [W-1:0] e;
    bit brAcc, sltAcc;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        mLastBr = 1'b0;
        pendBr  = 1'b0;
        pendSlt = 1'b0;
        brHeld  = 1'b0;
        sltHeld = 1'b0;
      end else begin
        if (pendBr)  chk("br_latency",  40'(o_br_rsp_valid),  40'(1));
        if (pendSlt) chk("slt_latency", 40'(o_slt_rsp_valid), 40'(1));
        pendBr  = 1'b0;
        pendSlt = 1'b0;
        if (o_br_rsp_valid || o_slt_rsp_valid)
          chk("single_outstanding", 40'(o_br_rsp_valid & o_slt_rsp_valid), 40'(0));
        if (brHeld)
          chk("br_hold", 40'({o_br_rsp_valid, o_br_illegal, o_br_taken}), 40'({1'b1, heldBr}));
        if (sltHeld)
          chk("slt_hold", 40'({o_slt_rsp_valid, o_slt_result}), 40'({1'b1, heldRes}));
        if (o_br_rsp_valid && brRspReady) begin
          if (exp_q.size() == 0) chk("br_unexpected_rsp", 40'(1), 40'(0));
          else begin
            e = exp_q.pop_front();
            chk("br_rsp", 40'({1'b0, o_br_illegal, 31'b0, o_br_taken}), 40'(e));
          end
        end
        if (o_slt_rsp_valid && sltRspReady) begin
          if (exp_q.size() == 0) chk("slt_unexpected_rsp", 40'(1), 40'(0));
          else begin
            e = exp_q.pop_front();
            chk("slt_rsp", 40'({1'b1, 1'b0, o_slt_result}), 40'(e));
          end
        end
        brHeld  = o_br_rsp_valid && !brRspReady;
        heldBr  = {o_br_illegal, o_br_taken};
        sltHeld = o_slt_rsp_valid && !sltRspReady;
        heldRes = o_slt_result;

        brAcc  = brValid && o_br_ready;
        sltAcc = sltValid && o_slt_ready;
        if (brAcc || sltAcc) begin
          chk("one_accept", 40'(brAcc && sltAcc), 40'(0));
          if (brValid && sltValid)
            chk("arb_winner", 40'(brAcc), 40'((FIXED_PRIO != 0) ? 1'b1 : !mLastBr));
          if (brAcc) begin
            exp_q.push_back(br_model(brRs1, brRs2, brF3));
            mLastBr = 1'b1;
            pendBr  = 1'b1;
          end else begin
            exp_q.push_back(slt_model(sltA, sltB, sltUns));
            mLastBr = 1'b0;
            pendSlt = 1'b1;
          end
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [XLEN-1:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return XLEN'($urandom);
      1:       return XLEN'($urandom_range(0, 3));
      2:       return 32'h8000_0000 | XLEN'($urandom_range(0, 3));
      default: return 32'hFFFF_FFFF - XLEN'($urandom_range(0, 3));
    endcase
  endfunction

  task automatic new_br_rand();
    brRs1 = rand_op();
    brRs2 = ($urandom_range(0, 3) == 0) ? brRs1 : rand_op();
    brF3  = 3'($urandom_range(0, 7));
    brValid = 1'b1;
  endtask

  task automatic new_slt_rand();
    sltA   = rand_op();
    sltB   = ($urandom_range(0, 3) == 0) ? sltA : rand_op();
    sltUns = 1'($urandom_range(0, 1));
    sltValid = 1'b1;
  endtask

  // One clock: observe accepts at the falling edge, update inputs just after the rise.
  task automatic cycle();
    @(negedge clk);
    brAccNow  = brValid && o_br_ready;
    sltAccNow = sltValid && o_slt_ready;
    if (brAccNow || sltAccNow) accCount++;
    if (brAccNow) brAccCount++;
    @(posedge clk);
    #1;
    if (brAccNow)  brValid  = 1'b0;
    if (sltAccNow) sltValid = 1'b0;
    if (fillBoth) begin
      if (!brValid)  new_br_rand();
      if (!sltValid) new_slt_rand();
    end
    if (randMode) begin
      if (!brValid  && $urandom_range(0, 1) == 1) new_br_rand();
      if (!sltValid && $urandom_range(0, 1) == 1) new_slt_rand();
      brRspReady  = ($urandom_range(0, 3) != 0);
      sltRspReady = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic send_br(input logic [XLEN-1:0] a, b, input logic [2:0] f3);
    brRs1 = a; brRs2 = b; brF3 = f3; brValid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (!brValid) return;
    end
    chk("br_accept_timeout", 40'(1), 40'(0));
    brValid = 1'b0;
  endtask

  task automatic drain();
    brRspReady  = 1'b1;
    sltRspReady = 1'b1;
    repeat (3) cycle();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    fork
      monitor();
    join_none

    // reset state, with reset asserted and after release
    #12;
    chk("reset_ctrl", 40'({o_br_ready, o_slt_ready, o_br_rsp_valid, o_slt_rsp_valid,
                           o_br_taken, o_br_illegal, dbgState}), 40'(0));
    chk("reset_result", 40'(o_slt_result), 40'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    cycle();
    chk("idle_ctrl", 40'({o_br_ready, o_slt_ready, o_br_rsp_valid, o_slt_rsp_valid,
                          o_br_taken, o_br_illegal, dbgState}), 40'(0));

    // first tie after reset goes to the branch, then SLT follows back-to-back
    brRs1 = 32'd7; brRs2 = 32'd9; brF3 = F3_BLT; brValid = 1'b1;
    sltA = 32'd3; sltB = 32'd2; sltUns = 1'b0; sltValid = 1'b1;
    cycle();
    chk("first_tie_br", 40'({o_br_rsp_valid, o_br_taken, brValid, sltValid}), 40'(4'b1101));
    for (int i = 0; i < 10; i++) if (sltValid) cycle();
    chk("tie_slt_done", 40'({o_slt_rsp_valid, sltValid}), 40'(2'b10));
    drain();

    // signed vs unsigned branch on the same operands
    send_br(32'hFFFF_FFFF, 32'd1, F3_BLT);
    chk("blt_taken", 40'({o_br_rsp_valid, o_br_taken}), 40'(2'b11));
    send_br(32'hFFFF_FFFF, 32'd1, F3_BLTU);
    chk("bltu_taken", 40'({o_br_rsp_valid, o_br_taken}), 40'(2'b10));

    // non-branch funct3 still gets a response; BEQ on equal operands
    send_br(32'd4, 32'd4, 3'b010);
    chk("illegal_f3", 40'({o_br_rsp_valid, o_br_taken, o_br_illegal}), 40'(3'b101));
    send_br(32'h1234, 32'h1234, F3_BEQ);
    chk("beq_equal", 40'({o_br_rsp_valid, o_br_taken, o_br_illegal}), 40'(3'b110));
    drain();

    // SLT response held while consumer stalls; nothing else may enter
    sltRspReady = 1'b0;
    sltA = 32'd5; sltB = 32'd5; sltUns = 1'b0; sltValid = 1'b1;
    for (int i = 0; i < 10; i++) if (sltValid) cycle();
    brRs1 = 32'd1; brRs2 = 32'd2; brF3 = F3_BNE; brValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("slt_stall", 40'({o_slt_rsp_valid, o_slt_ready, o_br_ready, brValid, o_slt_result}),
          40'({4'b1001, 32'd0}));
    end
    sltRspReady = 1'b1;
    cycle();
    chk("stall_release", 40'({o_br_rsp_valid, o_slt_rsp_valid, brValid, o_br_taken}),
        40'(4'b1001));
    drain();

    // throughput: both requesters always valid, responses always ready
    accCount = 0;
    brAccCount = 0;
    fillBoth = 1'b1;
    new_br_rand();
    new_slt_rand();
    repeat (20) cycle();
    fillBoth = 1'b0;
    brValid  = 1'b0;
    sltValid = 1'b0;
    chk("throughput", 40'(accCount), 40'(20));
    chk("alternation", 40'(brAccCount), 40'(10));
    drain();

    // asynchronous reset while a branch response is pending
    brRspReady = 1'b0;
    send_br(32'd10, 32'd3, F3_BGE);
    #2;
    chk("pre_reset_valid", 40'(o_br_rsp_valid), 40'(1));
    rst = 1'b1;
    #1;
    chk("async_reset_drop", 40'({o_br_rsp_valid, dbgState}), 40'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    brRspReady = 1'b1;
    cycle();

    // random traffic with random consumer back-pressure
    randMode = 1'b1;
    repeat (500) cycle();
    randMode = 1'b0;
    brRspReady  = 1'b1;
    sltRspReady = 1'b1;
    for (int i = 0; i < 30; i++) if (brValid || sltValid) cycle();
    chk("random_drained", 40'({brValid, sltValid}), 40'(0));
    drain();
    chk("queue_empty", 40'(exp_q.size()), 40'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
